// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one tinyalu between N_REQ requesters.
// One operation in flight at a time; a watchdog aborts hung operations and pulses the ALU reset.
module tinyalu_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   input  logic [3*N_REQ-1:0]   req_op,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [15:0]          rsp_result,
   output logic                 rsp_error,
   output logic                 alu_rst_n,
   output logic                 alu_start,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [2:0]           alu_op,
   input  logic                 alu_done,
   input  logic [15:0]          alu_result
);

   localparam int IW = $clog2(N_REQ);
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

   state_t          state;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   owner;
   logic [7:0]      a_q;
   logic [7:0]      b_q;
   logic [2:0]      op_q;
   logic [15:0]     result_q;
   logic            error_q;
   logic [WW-1:0]   wd;
   logic            abort_pulse;

   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand;

   // Search starts just past the previous owner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(last_grant) + k) % N_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign req_ready  = (state == IDLE && !reset && grant_found)
                       ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
   assign rsp_valid  = (state == RESPOND) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner) : '0;
   assign rsp_result = (state == RESPOND) ? result_q : 16'd0;
   assign rsp_error  = (state == RESPOND) ? error_q : 1'b0;
   assign alu_rst_n  = !(reset | abort_pulse);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= IW'(N_REQ - 1);
         owner       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         result_q    <= '0;
         error_q     <= 1'b0;
         wd          <= '0;
         alu_start   <= 1'b0;
         abort_pulse <= 1'b0;
      end else begin
         alu_start   <= 1'b0;
         abort_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  a_q       <= req_a[8*grant_idx +: 8];
                  b_q       <= req_b[8*grant_idx +: 8];
                  op_q      <= req_op[3*grant_idx +: 3];
                  owner     <= grant_idx;
                  // Start is registered so it lands exactly in the ISSUE cycle.
                  alu_start <= (req_op[3*grant_idx +: 3] != 3'b000);
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               wd <= '0;
               if (op_q != 3'b000) begin
                  state <= WAIT_DONE;
               end else begin
                  result_q <= '0;
                  error_q  <= 1'b0;
                  state    <= RESPOND;
               end
            end
            WAIT_DONE: begin
               wd <= wd + 1'b1;
               if (alu_done) begin
                  result_q <= alu_result;
                  error_q  <= 1'b0;
                  state    <= RESPOND;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  result_q    <= '0;
                  error_q     <= 1'b1;
                  abort_pulse <= 1'b1;
                  state       <= RESPOND;
               end
            end
            RESPOND: begin
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Bench for tinyalu_arbiter: behavioural tinyalu stub plus per-scenario checks against
// expectations derived from round-robin order, ALU arithmetic and the documented latencies.
module tb_tinyalu_arbiter;
   localparam int N = 4;
   localparam int T = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [N-1:0]     req_valid, req_ready, rsp_valid;
   logic [8*N-1:0]   req_a, req_b;
   logic [3*N-1:0]   req_op;
   logic [15:0]      rsp_result, alu_result;
   logic             rsp_error, alu_rst_n, alu_start, alu_done;
   logic [7:0]       alu_a, alu_b;
   logic [2:0]       alu_op;

   tinyalu_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
      .alu_rst_n(alu_rst_n), .alu_start(alu_start),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_done(alu_done), .alu_result(alu_result)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ALU stub and monitor state
   bit           hang = 0;
   int           lat_force = 0;
   bit           pending = 0;
   int           cnt = 0;
   logic [15:0]  pend_res = '0;
   int           start_cnt = 0;
   int           start_cyc = 0;
   int           cyc = 0;
   int           rstlow_cnt = 0;
   int           rstlow_cyc = 0;
   int           idle_viol = 0;
   logic [N-1:0] s_ready = '0;

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b001:  return 16'(a) + 16'(b);
         3'b010:  return {8'h00, a & b};
         3'b011:  return {8'h00, a ^ b};
         3'b100:  return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // Advance one clock; the tinyalu stub reacts to the registered start it sees.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      alu_done   = 1'b0;
      alu_result = '0;
      if (!alu_rst_n) begin
         rstlow_cnt++;
         rstlow_cyc = cyc;
         pending = 0;
      end
      if (pending) begin
         cnt--;
         if (cnt == 0) begin
            pending    = 0;
            alu_done   = 1'b1;
            alu_result = pend_res;
         end
      end
      if (alu_start) begin
         start_cnt++;
         start_cyc = cyc;
         if (!hang) begin
            pending  = 1;
            cnt      = (lat_force != 0) ? lat_force : ((alu_op == 3'b100) ? 4 : 1);
            pend_res = alu_fn(alu_op, alu_a, alu_b);
         end
      end
      #1;
      s_ready = req_ready;
      if (rsp_valid == '0 && (rsp_result != 16'd0 || rsp_error != 1'b0)) idle_viol++;
   endtask

   task automatic present(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[8*idx +: 8]  = a;
      req_b[8*idx +: 8]  = b;
      req_op[3*idx +: 3] = op;
      req_valid[idx]     = 1'b1;
   endtask

   task automatic wait_rsp(input int budget, output bit got, output int at, output logic [N-1:0] vec,
                           output logic [15:0] res, output logic err, output int busy);
      got = 0; at = 0; vec = '0; res = '0; err = 1'b0; busy = 0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (s_ready != '0) busy++;
         if (rsp_valid != '0) begin
            got = 1; at = cyc; vec = rsp_valid; res = rsp_result; err = rsp_error;
         end
      end
   endtask

   // Single request from one requester; returns what was observed, leaves DUT back in IDLE.
   task automatic do_txn(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input int budget, output logic [N-1:0] rdy, output int hs, output int lat,
                         output bit got, output logic [N-1:0] vec, output logic [15:0] res, output logic err);
      int at, busy;
      present(idx, a, b, op);
      #1;
      rdy = req_ready;
      hs = cyc;
      start_cnt = 0;
      step();
      req_valid[idx] = 1'b0;
      wait_rsp(budget, got, at, vec, res, err, busy);
      lat = at - hs;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1;
      step();
      step();
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", alu_start); end
      n_checks++; if (alu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_alu_rst_n got=%b exp=0", alu_rst_n); end
      req_valid = '0;
      reset = 1'b0;
      step();
      n_checks++; if (alu_rst_n !== 1'b1) begin n_fail++; $display("FAIL post_reset_alu_rst_n got=%b exp=1", alu_rst_n); end
      n_checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin n_fail++; $display("FAIL post_reset_operands got=%h exp=0", {alu_a, alu_b, alu_op}); end
   endtask

   task automatic test_add();
      logic [N-1:0] rdy, vec; int hs, lat; bit got; logic [15:0] res; logic err;
      do_txn(0, 8'd200, 8'd100, 3'b001, 20, rdy, hs, lat, got, vec, res, err);
      n_checks++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL add_ready got=%b exp=0001", rdy); end
      n_checks++; if (start_cyc - hs !== 1) begin n_fail++; $display("FAIL add_start_cycle got=%0d exp=1", start_cyc - hs); end
      n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL add_start_count got=%0d exp=1", start_cnt); end
      n_checks++; if (!got || lat !== 3) begin n_fail++; $display("FAIL add_latency got=%0d (seen=%0d) exp=3", lat, got); end
      n_checks++; if (vec !== 4'b0001) begin n_fail++; $display("FAIL add_owner got=%b exp=0001", vec); end
      n_checks++; if (res !== 16'd300) begin n_fail++; $display("FAIL add_result got=%0d exp=300", res); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_error got=%b exp=0", err); end
   endtask

   task automatic test_mul();
      logic [N-1:0] rdy, vec; int hs, lat; bit got; logic [15:0] res; logic err;
      do_txn(2, 8'hFF, 8'hFF, 3'b100, 20, rdy, hs, lat, got, vec, res, err);
      n_checks++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL mul_ready got=%b exp=0100", rdy); end
      n_checks++; if (!got || lat !== 6) begin n_fail++; $display("FAIL mul_latency got=%0d (seen=%0d) exp=6", lat, got); end
      n_checks++; if (vec !== 4'b0100) begin n_fail++; $display("FAIL mul_owner got=%b exp=0100", vec); end
      n_checks++; if (res !== 16'hFE01) begin n_fail++; $display("FAIL mul_result got=%h exp=fe01", res); end
      n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL mul_start_count got=%0d exp=1", start_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ra[N], rb[N];
      logic [N-1:0] exp_vec, vec; logic [15:0] exp_r, res; logic err;
      int last, exp_o, prev_hs, at, busy; bit got;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         ra[i] = 8'($urandom); rb[i] = 8'($urandom);
         present(i, ra[i], rb[i], 3'b011);
      end
      last = N - 1;
      prev_hs = 0;
      for (int g = 0; g < 5; g++) begin
         #1;
         exp_o   = (last + 1) % N;
         exp_vec = N'(1) << exp_o;
         n_checks++; if (req_ready !== exp_vec) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_vec); end
         if (g > 0) begin
            n_checks++; if (cyc - prev_hs !== 4) begin n_fail++; $display("FAIL rr_gap%0d got=%0d exp=4", g, cyc - prev_hs); end
         end
         prev_hs = cyc;
         exp_r = alu_fn(3'b011, ra[exp_o], rb[exp_o]);
         step();
         ra[exp_o] = 8'($urandom); rb[exp_o] = 8'($urandom);
         present(exp_o, ra[exp_o], rb[exp_o], 3'b011);
         wait_rsp(20, got, at, vec, res, err, busy);
         n_checks++; if (!got || at - prev_hs !== 3) begin n_fail++; $display("FAIL rr_latency%0d got=%0d (seen=%0d) exp=3", g, at - prev_hs, got); end
         n_checks++; if (vec !== exp_vec) begin n_fail++; $display("FAIL rr_owner%0d got=%b exp=%b", g, vec, exp_vec); end
         n_checks++; if (res !== exp_r) begin n_fail++; $display("FAIL rr_result%0d got=%h exp=%h", g, res, exp_r); end
         n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL rr_busy_ready%0d got=%0d exp=0", g, busy); end
         last = exp_o;
         step();
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_nop();
      logic [N-1:0] rdy, vec; int hs, lat; bit got; logic [15:0] res; logic err;
      do_txn(1, 8'h12, 8'h34, 3'b000, 20, rdy, hs, lat, got, vec, res, err);
      n_checks++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL nop_ready got=%b exp=0010", rdy); end
      n_checks++; if (start_cnt !== 0) begin n_fail++; $display("FAIL nop_start_count got=%0d exp=0", start_cnt); end
      n_checks++; if (!got || lat !== 2) begin n_fail++; $display("FAIL nop_latency got=%0d (seen=%0d) exp=2", lat, got); end
      n_checks++; if (vec !== 4'b0010) begin n_fail++; $display("FAIL nop_owner got=%b exp=0010", vec); end
      n_checks++; if (res !== 16'd0 || err !== 1'b0) begin n_fail++; $display("FAIL nop_result got=%h/%b exp=0/0", res, err); end
   endtask

   task automatic test_timeout();
      logic [N-1:0] rdy, vec; int hs, lat; bit got; logic [15:0] res; logic err;
      hang = 1;
      rstlow_cnt = 0;
      do_txn(3, 8'd5, 8'd6, 3'b001, 40, rdy, hs, lat, got, vec, res, err);
      hang = 0;
      n_checks++; if (!got || lat !== T + 2) begin n_fail++; $display("FAIL to_latency got=%0d (seen=%0d) exp=%0d", lat, got, T + 2); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_error got=%b exp=1", err); end
      n_checks++; if (res !== 16'd0) begin n_fail++; $display("FAIL to_result got=%h exp=0", res); end
      n_checks++; if (rstlow_cnt !== 1) begin n_fail++; $display("FAIL to_alu_rst_cycles got=%0d exp=1", rstlow_cnt); end
      n_checks++; if (rstlow_cyc - hs !== T + 2) begin n_fail++; $display("FAIL to_alu_rst_when got=%0d exp=%0d", rstlow_cyc - hs, T + 2); end
      do_txn(3, 8'd9, 8'd7, 3'b010, 20, rdy, hs, lat, got, vec, res, err);
      n_checks++; if (!got || lat !== 3 || vec !== 4'b1000) begin n_fail++; $display("FAIL to_recover_rsp got=%0d/%b exp=3/1000", lat, vec); end
      n_checks++; if (res !== 16'd1 || err !== 1'b0) begin n_fail++; $display("FAIL to_recover_result got=%h/%b exp=1/0", res, err); end
      // Done arriving in the very last watchdog cycle must win over the abort.
      lat_force = T;
      rstlow_cnt = 0;
      do_txn(0, 8'd3, 8'd4, 3'b001, 40, rdy, hs, lat, got, vec, res, err);
      lat_force = 0;
      n_checks++; if (!got || lat !== T + 2) begin n_fail++; $display("FAIL late_done_latency got=%0d exp=%0d", lat, T + 2); end
      n_checks++; if (res !== 16'd7 || err !== 1'b0) begin n_fail++; $display("FAIL late_done_result got=%h/%b exp=7/0", res, err); end
      n_checks++; if (rstlow_cnt !== 0) begin n_fail++; $display("FAIL late_done_alu_rst got=%0d exp=0", rstlow_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] vec; logic [15:0] res; logic err; int at, busy, hs; bit got;
      present(2, 8'hFF, 8'h02, 3'b100);
      #1;
      step();
      req_valid = '0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_rsp(12, got, at, vec, res, err, busy);
      n_checks++; if (got !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp got=%b exp=0", got); end
      present(3, 8'd1, 8'd1, 3'b001);
      present(0, 8'd10, 8'd20, 3'b001);
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_grant got=%b exp=0001", req_ready); end
      hs = cyc;
      step();
      req_valid = '0;
      wait_rsp(20, got, at, vec, res, err, busy);
      n_checks++; if (!got || at - hs !== 3 || vec !== 4'b0001) begin n_fail++; $display("FAIL midreset_rsp got=%0d/%b exp=3/0001", at - hs, vec); end
      n_checks++; if (res !== 16'd30) begin n_fail++; $display("FAIL midreset_result got=%0d exp=30", res); end
      step();
   endtask

   task automatic test_idle_outputs();
      n_checks++; if (idle_viol !== 0) begin n_fail++; $display("FAIL idle_rsp_nonzero got=%0d exp=0", idle_viol); end
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      alu_done   = 1'b0;
      alu_result = '0;
      test_reset();
      test_add();
      test_mul();
      test_back_to_back();
      test_nop();
      test_timeout();
      test_reset_mid();
      test_idle_outputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "bench timeout");
   end
endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
Round-robin arbiter that shares one tinyalu instance between N_REQ requesters. It accepts one request at a time over a valid/ready handshake and issues a single-cycle start pulse to the ALU. It then waits for ALU done and routes the result back to the owning requester. A watchdog aborts hung operations and pulses the ALU reset to recover.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles spent in WAIT_DONE before abort (>= 8)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_a  in  8*N_REQ  packed operand A, requester i at [8i+7:8i]
req_b  in  8*N_REQ  packed operand B
req_op  in  3*N_REQ  packed opcode (001 add, 010 and, 011 xor, 100 mul, 000 nop)
rsp_valid  out  N_REQ  one-cycle response strobe to owner, one-hot or zero
rsp_result  out  16  result, valid when any rsp_valid bit is set
rsp_error  out  1  timeout flag, valid with rsp_valid
alu_rst_n  out  1  ALU reset, active-low
alu_start  out  1  ALU start pulse
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_op  out  3  ALU opcode
alu_done  in  1  ALU done
alu_result  in  16  ALU result

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
- Reset: state IDLE; last_grant = N_REQ-1, so requester 0 wins first; operand and result regs 0; all outputs 0 except alu_rst_n = 0 during reset.
- Reset mid-operation aborts with no response.
- alu_rst_n = !(reset | abort_pulse), combinational from registered abort_pulse.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 with wrap-around.
  - req_ready[grant] = 1 in the same cycle (combinational).
  - Latch A/B/op and owner; next state ISSUE.
  - No valid: stay IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - If op != 000: alu_start = 1; next WAIT_DONE; watchdog cleared to 0.
  - If op == 000: no start; result reg = 0, error = 0; next RESPOND.
- WAIT_DONE:
  - alu_start = 0; alu_a/b/op held at latched values. This holds for ISSUE and WAIT_DONE.
  - Watchdog increments each cycle.
  - alu_done = 1: capture alu_result, error = 0, next RESPOND. alu_done wins over timeout in the same cycle.
  - Watchdog == TIMEOUT-1 without done: result = 0, error = 1, abort_pulse = 1 for next cycle; next RESPOND.
- RESPOND (1 cycle):
  - rsp_valid[owner] = 1; rsp_result and rsp_error driven from regs.
  - last_grant = owner; next IDLE.
- alu_done outside WAIT_DONE is ignored.
- req_ready is never asserted outside IDLE.
- rsp_result = 0 and rsp_error = 0 when no rsp_valid.
- Requester must hold valid and operands until ready. A valid drop before grant is legal and simply not granted.
- Latency with tinyalu, handshake at cycle 0:
  - add/and/xor: done at cycle 2, rsp_valid at cycle 3.
  - mul: done at cycle 5, rsp_valid at cycle 6.
  - nop: rsp_valid at cycle 2.
- Back-to-back: next handshake at earliest one cycle after RESPOND, i.e. cycle 4 for add.

Test Plan:
- Reset, then req 0 add A=8'd200 B=8'd100 -> req_ready[0] at cycle 0; alu_start single pulse at cycle 1; rsp_valid[0] at cycle 3 with result 16'd300, error 0.
- Req 2 mul A=8'hFF B=8'hFF -> rsp_valid[2] at cycle 6, result 16'hFE01; alu_start pulses exactly once.
- All 4 valid continuously, each xor with distinct operands -> grant order 0,1,2,3,0; each rsp_valid goes to the correct owner with its own result.
- Req 1 op 000 -> no alu_start; rsp_valid[1] at cycle 2, result 0, error 0.
- ALU model never asserts done -> rsp_error = 1 and result 0 after TIMEOUT cycles in WAIT_DONE; alu_rst_n low one cycle; next request then completes normally.
- Reset asserted during WAIT_DONE of a mul -> no rsp_valid; state IDLE; subsequent requester 0 request granted first.
